// File: rtl/bz_rx_buffer_pkg.sv
// Shared constants and types for the BZ receive buffer.
package bz_rx_pkg;

    // Width of a BZ word including the tail bit.
    localparam int NBZWORD_DEFAULT = 11;

    // Position of the tail bit inside a BZ word.
    localparam int TAIL_BIT = 10;

    typedef logic [NBZWORD_DEFAULT-1:0] bz_word_t;

    // Chip-side 4-phase handshake states.
    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_LOW = 1'b1
    } bz_hs_state_e;

    // True when the word closes a BZ packet.
    function automatic logic is_tail(input bz_word_t w);
        return w[TAIL_BIT];
    endfunction

endpackage

// File: rtl/bz_rx_buffer_sync_ff.sv
// NSYNC-deep single-bit synchronizer with asynchronous active-low clear.
module sync_ff #(
    parameter int NSYNC = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [NSYNC-1:0] sync_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking assignment so every flop samples the value from before the edge.
            sync_q <= {sync_q[NSYNC-2:0], d_i};
        end
    end

    assign q_o = sync_q[NSYNC-1];

endmodule

// File: rtl/bz_rx_buffer.sv
// Receive buffer: accepts BZ words over an async 4-phase handshake and
// presents them to the deserializer as a show-ahead FIFO.
module bz_rx_buffer
    import bz_rx_pkg::*;
#(
    parameter int NBZword = NBZWORD_DEFAULT,
    parameter int DEPTH   = 16,
    parameter int NSYNC   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NBZword-1:0]         bz_data_in,
    input  logic                       bz_req_in,
    output logic                       bz_ack_out,
    output logic [NBZword-1:0]         data_out,
    output logic                       isempty,
    input  logic                       rdreq,
    output logic [$clog2(DEPTH+1)-1:0] fill_level
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    bz_hs_state_e     state_q, state_d;
    logic             ack_q, ack_d;
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    fill_q;
    logic [NBZword-1:0] mem [DEPTH];

    logic req_s;
    logic full;
    logic wr_en;
    logic rd_en;

    sync_ff #(
        .NSYNC (NSYNC)
    ) u_req_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (bz_req_in),
        .q_o   (req_s)
    );

    assign full    = (fill_q == FULL_CNT);
    assign isempty = (fill_q == '0);
    assign rd_en   = rdreq && !isempty;

    // Handshake next-state: capture on a fresh request when space exists, then wait for req to drop.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_d = state_q;
        ack_d   = ack_q;
        wr_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_s && !full) begin
                    wr_en   = 1'b1;
                    ack_d   = 1'b1;
                    state_d = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ack_d   = 1'b0;
            end
        endcase
    end

    // Handshake state and ack register; ack leaves the block straight from this flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end

    assign bz_ack_out = ack_q;

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            unique case ({wr_en, rd_en})
                2'b10:   fill_q <= fill_q + CW'(1);
                2'b01:   fill_q <= fill_q - CW'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end

    // Word storage; contents are qualified by the pointers and count.
    // NOTE: the memory has no reset, so it can map onto plain RAM/LUT storage.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= bz_data_in;
        end
    end

    // Show-ahead head word, forced to zero while empty.
    always_comb begin
        data_out = '0;
        if (!isempty) begin
            data_out = mem[rd_ptr_q];
        end
    end

    assign fill_level = fill_q;

endmodule

// File: tb/tb_bz_rx_buffer.sv
// Self-checking bench for bz_rx_buffer: chip handshake model, consumer and
// a scoreboard queue of words expected on data_out.
module tb_bz_rx_buffer;

    localparam int NBZ   = 11;
    localparam int DEPTH = 16;
    localparam int NSYNC = 2;
    localparam int CW    = $clog2(DEPTH+1);

    logic           clk;
    logic           reset;
    logic [NBZ-1:0] bz_data_in;
    logic           bz_req_in;
    logic           bz_ack_out;
    logic [NBZ-1:0] data_out;
    logic           isempty;
    logic           rdreq;
    logic [CW-1:0]  fill_level;

    int n_cmp;
    int n_err;
    logic [NBZ-1:0] sb [$];

    bz_rx_buffer #(
        .NBZword (NBZ),
        .DEPTH   (DEPTH),
        .NSYNC   (NSYNC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bz_data_in (bz_data_in),
        .bz_req_in  (bz_req_in),
        .bz_ack_out (bz_ack_out),
        .data_out   (data_out),
        .isempty    (isempty),
        .rdreq      (rdreq),
        .fill_level (fill_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Full 4-phase transfer of one word; expected word goes to the scoreboard.
    task automatic chip_send(input logic [NBZ-1:0] w);
        int n;
        @(negedge clk);
        bz_data_in = w;
        bz_req_in  = 1'b1;
        sb.push_back(w);
        n = 0;
        while (!bz_ack_out && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("ack_rise", bz_ack_out, 1);
        bz_req_in = 1'b0;
        n = 0;
        while (bz_ack_out && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("ack_fall", bz_ack_out, 0);
    endtask

    // Compare head against scoreboard, then pop it on the next edge.
    task automatic pop_check(input string tag);
        logic [NBZ-1:0] exp;
        @(negedge clk);
        exp = (sb.size() > 0) ? sb.pop_front() : '0;
        check(tag, data_out, exp);
        rdreq = 1'b1;
        @(negedge clk);
        rdreq = 1'b0;
    endtask

    initial begin
        int edge_n;
        int cnt;
        int got;
        bit phase;
        int guard;

        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b0;
        rdreq      = 1'b0;
        bz_req_in  = 1'b1;
        bz_data_in = 11'h155;

        // 1. Reset with request held high.
        repeat (3) @(negedge clk);
        check("rst_ack", bz_ack_out, 0);
        check("rst_empty", isempty, 1);
        check("rst_data", data_out, 0);
        check("rst_fill", fill_level, 0);
        sb.push_back(11'h155);
        reset  = 1'b1;
        edge_n = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (bz_ack_out && edge_n == 0) edge_n = i;
        end
        check("rst_first_ack_edge", edge_n, NSYNC + 1);
        check("rst_one_capture", fill_level, 1);
        @(negedge clk);
        bz_req_in = 1'b0;
        cnt = 0;
        while (bz_ack_out && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("rst_ack_drop", bz_ack_out, 0);
        pop_check("rst_word");
        check("rst_drained", isempty, 1);

        // 2. Single word with release-latency check.
        @(negedge clk);
        bz_data_in = 11'b01011011100;
        bz_req_in  = 1'b1;
        sb.push_back(11'b01011011100);
        cnt = 0;
        while (!bz_ack_out && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("single_ack", bz_ack_out, 1);
        bz_req_in = 1'b0;
        cnt = 0;
        while (bz_ack_out && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("single_ack_fall_2to3", (cnt >= 2 && cnt <= 3), 1);
        check("single_not_empty", isempty, 0);
        check("single_fill", fill_level, 1);
        pop_check("single_data");
        check("single_empty", isempty, 1);
        check("single_fill0", fill_level, 0);

        // 3. Burst of 40 words against a consumer popping every other cycle.
        got = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) chip_send(NBZ'(i));
            end
            begin
                phase = 1'b0;
                guard = 0;
                while (got < 40 && guard < 4000) begin
                    @(negedge clk);
                    guard++;
                    if (phase && !isempty && sb.size() > 0) begin
                        check("burst_data", data_out, sb.pop_front());
                        rdreq = 1'b1;
                        got++;
                    end else begin
                        rdreq = 1'b0;
                    end
                    phase = !phase;
                end
                @(negedge clk);
                rdreq = 1'b0;
            end
        join
        check("burst_count", got, 40);
        check("burst_drained", isempty, 1);

        // 4. Fill to DEPTH, then a 17th request must stall until a pop.
        for (int i = 0; i < DEPTH; i++) chip_send(NBZ'(11'h100 + i));
        check("full_fill", fill_level, DEPTH);
        @(negedge clk);
        bz_data_in = 11'b01111001111;
        bz_req_in  = 1'b1;
        repeat (8) @(negedge clk);
        check("full_no_ack", bz_ack_out, 0);
        check("full_fill_hold", fill_level, DEPTH);
        sb.push_back(11'b01111001111);
        pop_check("full_head");
        cnt = 1;
        while (!bz_ack_out && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("full_accept_lat", (cnt <= NSYNC + 1), 1);
        check("full_refill", fill_level, DEPTH);
        bz_req_in = 1'b0;
        cnt = 0;
        while (bz_ack_out && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("full_ack_fall", bz_ack_out, 0);
        for (int i = 0; i < DEPTH; i++) pop_check("full_drain");
        check("full_drained", isempty, 1);

        // 5. Simultaneous push and pop at fill_level 1.
        chip_send(11'b01110110101);
        @(negedge clk);
        bz_data_in = 11'b01111111111;
        bz_req_in  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rw_head_old", data_out, sb.pop_front());
        check("rw_pre_ack", bz_ack_out, 0);
        rdreq = 1'b1;
        @(negedge clk);
        rdreq = 1'b0;
        sb.push_back(11'b01111111111);
        check("rw_ack", bz_ack_out, 1);
        check("rw_fill", fill_level, 1);
        check("rw_head_new", data_out, 11'b01111111111);
        bz_req_in = 1'b0;
        cnt = 0;
        while (bz_ack_out && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        pop_check("rw_drain");
        check("rw_empty", isempty, 1);

        // 6. Reads while empty change nothing; then reset mid-handshake.
        @(negedge clk);
        rdreq = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("empty_rd_fill", fill_level, 0);
            check("empty_rd_data", data_out, 0);
        end
        rdreq = 1'b0;
        chip_send(11'h2A5);
        chip_send(11'h05A);
        pop_check("empty_rd_ptr0");
        pop_check("empty_rd_ptr1");
        @(negedge clk);
        bz_data_in = 11'h3C3;
        bz_req_in  = 1'b1;
        cnt = 0;
        while (!bz_ack_out && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("midrst_ack_up", bz_ack_out, 1);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_ack_async", bz_ack_out, 0);
        check("midrst_empty", isempty, 1);
        check("midrst_fill", fill_level, 0);
        check("midrst_data", data_out, 0);
        bz_req_in = 1'b0;
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_idle", bz_ack_out, 0);
        chip_send(11'h4E1);
        pop_check("post_rst_word");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bz_rx_buffer.md
Name: bz_rx_buffer

Overview:
Input stage of the BrainStorm-to-PC path, directly upstream of the BZ deserializer.
- Receives 11-bit BZ words from the chip over an asynchronous 4-phase bundled-data handshake.
- Synchronizes the handshake into clk and buffers the words.
- Presents them to the deserializer as a show-ahead FIFO (data_out / isempty / rdreq).
- Applies backpressure to the chip by withholding ack when full.

Parameters:
NBZword, 11, BZ word width incl. tail bit (bit 10 = tail)
DEPTH, 16, buffer entries; power of two, >= 4
NSYNC, 2, synchronizer flops on bz_req_in, >= 2

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
bz_data_in  input  NBZword  chip data; stable while bz_req_in high (bundled data)
bz_req_in  input  1  chip request (async)
bz_ack_out  output  1  acknowledge to chip
data_out  output  NBZword  head-of-queue word (show-ahead); 0 when isempty
isempty  output  1  buffer empty
rdreq  input  1  pop head word; ignored when isempty
fill_level  output  $clog2(DEPTH+1)  entries held

Behaviour:
Reset (reset=0, async):
- rd_ptr, wr_ptr, and fill_level clear to 0.
- FSM goes to IDLE; bz_ack_out=0; isempty=1; data_out=0.
- Synchronizer flops clear to 0.

Handshake FSM, evaluated on req_s (bz_req_in after NSYNC flops):
- IDLE:
  - req_s=1 and fill_level<DEPTH: write bz_data_in into mem[wr_ptr], wr_ptr++, set bz_ack_out=1, go to WAIT_LOW.
  - req_s=1 and full: stay in IDLE with ack=0; the chip stalls.
- WAIT_LOW:
  - req_s=0: bz_ack_out=0, go to IDLE.
  - Otherwise hold ack=1. No capture occurs in this state.

Handshake latency:
- bz_req_in rises before edge 0 → req_s=1 after edge NSYNC-1 → write and ack at edge NSYNC.
- isempty falls after that same edge.
- bz_ack_out is driven directly from a flop (no combinational path to the chip).

FIFO:
- Memory is not reset.
- data_out = mem[rd_ptr] when !isempty, else 0.
- rdreq && !isempty at an edge increments rd_ptr.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- fill_level: +1 on write only, -1 on read only, unchanged on simultaneous read and write.
- isempty = (fill_level==0). Full = (fill_level==DEPTH).

Boundary conditions:
- Simultaneous read and write when full: no write is possible, because the write is gated on the registered full.
- Read while full frees an entry. A pending req_s=1 is then accepted at the next edge.
- Simultaneous read and write at fill_level==1: the read pops the old head; the new word becomes the head.
- rdreq while empty: no pointer or count change.
- Reset mid-handshake: ack drops immediately. If the chip still holds req high after reset release, the word is captured again. Duplication is accepted; the chip side is reset together with this block.

Decomposition:
- Package bz_rx_pkg holds:
  - NBZword default constant
  - TAIL_BIT=10 constant
  - typedef bz_word_t (logic [10:0])
  - FSM enum {IDLE, WAIT_LOW}
- Sub-module: sync_ff, a NSYNC-deep single-bit synchronizer with async active-low clear.
- FIFO storage and pointers stay inline.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with bz_req_in=1 → bz_ack_out=0, isempty=1, data_out=0, fill_level=0. After release, the first ack rises exactly NSYNC+1 edges later (NSYNC=2 → 3rd edge).
2. Single word: bz_data_in=11'b01011011100, req up, wait for ack, req down → ack low 2–3 cycles after req falls; isempty=0; data_out=11'b01011011100; one rdreq → isempty=1, fill_level=0.
3. Burst and wrap: chip model sends 40 words 0x000..0x027 while the consumer pops with rdreq every other cycle → all 40 appear in order on data_out, no loss or duplicate, pointers wrap ≥2 times.
4. Full backpressure: rdreq=0, send 17 words with DEPTH=16 → fill_level=16, 17th req stays unacked. Pulse rdreq once → 17th word (11'b01111001111) accepted within NSYNC+1 cycles, fill_level returns to 16.
5. Simultaneous read/write at fill_level=1 (head 11'b01110110101) with an incoming write of 11'b01111111111 → fill_level stays 1, data_out=11'b01111111111 next cycle.
6. Empty read: rdreq=1 for 5 cycles while isempty=1 → pointers and fill_level unchanged, data_out=0. Then assert reset mid-WAIT_LOW → ack drops asynchronously, FIFO empties.
